// File: rtl/rx_lane_130b_decoder.sv
// -----------------------------------------------------------------------------
// rx_lane_130b_decoder
//
// Single-lane 128b/130b receive decoder. Serial lane bits are shifted into a
// 130-bit window. Block alignment is acquired from the 2-bit sync headers
// (HUNT -> VERIFY -> LOCKED). Each aligned block's 128-bit payload is then
// emitted together with its block type.
//
// Optional feature macro: RX_DESCRAMBLE_EN
//   When defined, data-block payloads are descrambled with a Galois LFSR
//   (x^23+x^21+x^16+x^8+x^5+x^2+1, 128 steps per block, bit 0 first).
//   When undefined, payloads pass through and no LFSR is built.
//
// Parameters
//   LOCK_CNT    consecutive valid headers needed to declare lock (1..15)
//   UNLOCK_CNT  consecutive invalid headers, while locked, forcing re-hunt
//   LFSR_SEED   descrambler seed
//
// Ports
//   clk8       in   bit-rate clock, rising edge
//   rst1       in   synchronous active-high reset
//   bit_valid  in   qualifies bit_in; all state advances only when high
//   bit_in     in   serial lane bit, first-transmitted first
//   blk_valid  out  one-cycle pulse, blk_data/blk_os hold a new block
//   blk_os     out  1 = ordered set (hdr 2'b10), 0 = data block (hdr 2'b01)
//   blk_data   out  128-bit payload, byte 0 = blk_data[7:0] (first received)
//   locked     out  high while in LOCKED
//   hdr_err    out  one-cycle pulse, invalid header at a boundary
// -----------------------------------------------------------------------------
module rx_lane_130b_decoder #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter logic [22:0] LFSR_SEED  = 23'h1DBFBC
) (
    input  logic         clk8,
    input  logic         rst1,
    input  logic         bit_valid,
    input  logic         bit_in,
    output logic         blk_valid,
    output logic         blk_os,
    output logic [127:0] blk_data,
    output logic         locked,
    output logic         hdr_err
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] BLK_LAST  = 8'd129;
    localparam logic [7:0] FILL_MAX  = 8'd130;
    localparam logic [4:0] LOCK_TH   = 5'(LOCK_CNT);
    localparam logic [4:0] UNLOCK_TH = 5'(UNLOCK_CNT);

    state_t       state, state_n;
    // The oldest window bit is only ever consumed in the shifted view below,
    // so only bits 129:1 need to be stored.
    logic [129:1] sr_hi, sr_hi_n;
    logic [129:0] sr;           // window after this cycle's shift
    logic [7:0]   fill, fill_n;
    logic [7:0]   bit_cnt, bit_cnt_n;
    logic [3:0]   good_cnt, good_n;
    logic [3:0]   bad_cnt, bad_n;
    logic [7:0]   fill_inc, bit_inc;
    logic [4:0]   good_inc, bad_inc;
    logic         hdr_ok;
    logic         blk_fire, err_fire;
    logic [127:0] payload;

    assign sr       = {bit_in, sr_hi};
    assign hdr_ok   = sr[1] ^ sr[0];
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + 8'd1;
    assign bit_inc  = (bit_cnt == BLK_LAST) ? 8'd0 : bit_cnt + 8'd1;
    assign good_inc = {1'b0, good_cnt} + 5'd1;
    assign bad_inc  = {1'b0, bad_cnt} + 5'd1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk8) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst1) begin
            state    <= HUNT;
            sr_hi    <= '0;
            fill     <= '0;
            bit_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_n;
            sr_hi    <= sr_hi_n;
            fill     <= fill_n;
            bit_cnt  <= bit_cnt_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n   = state;
        sr_hi_n   = sr_hi;
        fill_n    = fill;
        bit_cnt_n = bit_cnt;
        good_n    = good_cnt;
        bad_n     = bad_cnt;
        blk_fire  = 1'b0;
        err_fire  = 1'b0;

        if (bit_valid) begin
            sr_hi_n = sr[129:1];
            unique case (state)
                HUNT: begin
                    // Every bit is a fresh alignment candidate once the window
                    // is full: this gives the implicit 1-bit slip.
                    fill_n = fill_inc;
                    if (fill_inc == FILL_MAX && hdr_ok) begin
                        state_n   = (LOCK_TH <= 5'd1) ? LOCKED : VERIFY;
                        good_n    = 4'd1;
                        bad_n     = 4'd0;
                        bit_cnt_n = 8'd0;
                    end
                end
                VERIFY: begin
                    bit_cnt_n = bit_inc;
                    if (bit_inc == 8'd0) begin
                        if (hdr_ok) begin
                            good_n = good_inc[3:0];
                            if (good_inc >= LOCK_TH) begin
                                state_n = LOCKED;
                                bad_n   = 4'd0;
                            end
                        end else begin
                            state_n  = HUNT;
                            fill_n   = 8'd0;
                            err_fire = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_n = bit_inc;
                    if (bit_inc == 8'd0) begin
                        blk_fire = 1'b1;
                        if (hdr_ok) begin
                            bad_n = 4'd0;
                        end else begin
                            bad_n    = bad_inc[3:0];
                            err_fire = 1'b1;
                            if (bad_inc >= UNLOCK_TH) begin
                                state_n = HUNT;
                                fill_n  = 8'd0;
                            end
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Payload path (optional descrambler)
    // -------------------------------------------------------------------------
`ifdef RX_DESCRAMBLE_EN
    // Taps for x^21, x^16, x^8, x^5, x^2 and x^0; x^23 is the feedback bit.
    localparam logic [22:0] LFSR_TAPS = 23'h210125;

    typedef struct packed {
        logic [22:0]  next;
        logic [127:0] mask;
    } lfsr_run_t;

    // Runs the LFSR 128 steps from 'seed'; mask bit i scrambles payload bit i.
    function automatic lfsr_run_t lfsr_run(input logic [22:0] seed);
        lfsr_run_t   r;
        logic [22:0] s;
        logic        fb;
        r = '0;
        s = seed;
        for (int i = 0; i < 128; i++) begin
            fb        = s[22];
            r.mask[i] = fb;
            s         = {s[21:0], 1'b0} ^ (fb ? LFSR_TAPS : 23'd0);
        end
        r.next = s;
        return r;
    endfunction

    logic [22:0] lfsr, lfsr_n;
    lfsr_run_t   run;

    always_comb begin
        run     = lfsr_run(lfsr);
        lfsr_n  = lfsr;
        payload = sr[129:2];
        if (state_n == LOCKED && state != LOCKED) begin
            lfsr_n = LFSR_SEED;
        end else if (blk_fire) begin
            if (!sr[1]) begin
                payload = sr[129:2] ^ run.mask;
                lfsr_n  = run.next;
            end else if (sr[9:2] == 8'h00) begin
                lfsr_n = LFSR_SEED;
            end
        end
    end

    always_ff @(posedge clk8) begin
        if (rst1) lfsr <= LFSR_SEED;
        else      lfsr <= lfsr_n;
    end
`else
    assign payload = sr[129:2];
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk8) begin
        if (rst1) begin
            blk_valid <= 1'b0;
            hdr_err   <= 1'b0;
            blk_os    <= 1'b0;
            // NOTE: the payload register is reset because it is a visible
            // output with a defined reset value, not internal storage.
            blk_data  <= '0;
        end else begin
            blk_valid <= blk_fire;
            hdr_err   <= err_fire;
            if (blk_fire) begin
                blk_data <= payload;
                blk_os   <= sr[1];
            end
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

endmodule

// File: tb/tb_rx_lane_130b_decoder.sv
// -----------------------------------------------------------------------------
// tb_rx_lane_130b_decoder
//
// Scoreboard bench for rx_lane_130b_decoder. The driver feeds serial bits and
// runs a bit-window reference model that pushes expected block / header-error
// events into a queue. A monitor on the falling edge pops and compares every
// event the DUT presents, and checks locked and held outputs each cycle.
// -----------------------------------------------------------------------------
module tb_rx_lane_130b_decoder;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 4;
    localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic         clk8      = 1'b0;
    logic         rst1      = 1'b1;
    logic         bit_valid = 1'b0;
    logic         bit_in    = 1'b0;
    logic         blk_valid;
    logic         blk_os;
    logic [127:0] blk_data;
    logic         locked;
    logic         hdr_err;

    rx_lane_130b_decoder #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .LFSR_SEED  (23'h1DBFBC)
    ) dut (
        .clk8      (clk8),
        .rst1      (rst1),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .blk_valid (blk_valid),
        .blk_os    (blk_os),
        .blk_data  (blk_data),
        .locked    (locked),
        .hdr_err   (hdr_err)
    );

    always #5 clk8 = ~clk8;

    typedef struct {
        bit         blk;
        bit         err;
        bit         os;
        bit [127:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  errors   = 0;
    int  checks   = 0;
    int  blk_seen = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: the last 130 qualified bits as a queue, alignment kept
    // as a bit-phase counter, lock status as a mode number.
    // -------------------------------------------------------------------------
    bit         win[$];
    int         m_mode;     // 0 hunt, 1 verify, 2 locked
    int         m_fill, m_phase, m_good, m_bad;
    bit [127:0] m_last_data;
    bit         m_last_os;

`ifdef RX_DESCRAMBLE_EN
    localparam logic [22:0] SEED = 23'h1DBFBC;
    bit [22:0] m_lfsr;
    // Descramble one data payload, polynomial given by its exponents.
    function automatic bit [127:0] descramble(input bit [127:0] p, inout bit [22:0] s);
        int exps[6] = '{21, 16, 8, 5, 2, 0};
        bit fb;
        for (int i = 0; i < 128; i++) begin
            fb   = s[22];
            p[i] = p[i] ^ fb;
            s    = s << 1;
            if (fb) foreach (exps[k]) s[exps[k]] = ~s[exps[k]];
        end
        return p;
    endfunction
`endif

    task automatic enter_lock();
        m_mode = 2;
        m_bad  = 0;
`ifdef RX_DESCRAMBLE_EN
        m_lfsr = SEED;
`endif
    endtask

    task automatic model_step(input bit v, input bit b, input bit r);
        bit         ok;
        bit [127:0] pay;
        ev_t        e;
        if (r) begin
            win.delete();
            m_mode = 0; m_fill = 0; m_phase = 0; m_good = 0; m_bad = 0;
            m_last_data = '0; m_last_os = 1'b0;
`ifdef RX_DESCRAMBLE_EN
            m_lfsr = SEED;
`endif
            return;
        end
        if (!v) return;
        win.push_back(b);
        if (win.size() > 130) void'(win.pop_front());
        ok = (win.size() == 130) && (win[0] != win[1]);
        if (m_mode == 0) begin
            m_fill = (m_fill < 130) ? m_fill + 1 : 130;
            if (m_fill == 130 && ok) begin
                m_good = 1; m_phase = 0; m_bad = 0;
                if (m_good >= LOCK_CNT) enter_lock();
                else m_mode = 1;
            end
        end else begin
            m_phase = (m_phase + 1) % 130;
            if (m_phase == 0) begin
                if (m_mode == 1) begin
                    if (ok) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) enter_lock();
                    end else begin
                        m_mode = 0; m_fill = 0;
                        e = '{blk: 1'b0, err: 1'b1, os: 1'b0, data: '0};
                        exp_q.push_back(e);
                    end
                end else begin
                    for (int i = 0; i < 128; i++) pay[i] = win[i + 2];
                    e.blk = 1'b1;
                    e.err = !ok;
                    e.os  = win[1];
                    e.data = pay;
`ifdef RX_DESCRAMBLE_EN
                    if (!e.os) e.data = descramble(pay, m_lfsr);
                    else if (pay[7:0] == 8'h00) m_lfsr = SEED;
`endif
                    exp_q.push_back(e);
                    m_last_data = e.data;
                    m_last_os   = e.os;
                    if (ok) m_bad = 0;
                    else begin
                        m_bad++;
                        if (m_bad >= UNLOCK_CNT) begin m_mode = 0; m_fill = 0; end
                    end
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    always @(negedge clk8) begin
        ev_t e;
        if (mon_en) begin
            check("locked", {127'd0, locked}, {127'd0, m_mode == 2});
            if (blk_valid !== 1'b1) begin
                check("hold_data", blk_data, m_last_data);
                check("hold_os", {127'd0, blk_os}, {127'd0, m_last_os});
            end
            if (blk_valid === 1'b1 || hdr_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {126'd0, blk_valid, hdr_err}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_valid", {127'd0, blk_valid}, {127'd0, e.blk});
                    check("hdr_err", {127'd0, hdr_err}, {127'd0, e.err});
                    if (e.blk) begin
                        blk_seen++;
                        check("blk_os", {127'd0, blk_os}, {127'd0, e.os});
                        check("blk_data", blk_data, e.data);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk8);
        #1;
        model_step(bit_valid, bit_in, rst1);
    endtask

    task automatic send_bit(input bit b, input bit gaps);
        bit done = 1'b0;
        while (!done) begin
            bit_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bit_in    = bit_valid ? b : 1'($urandom_range(0, 1));
            tick();
            done = bit_valid;
        end
    endtask

    task automatic send_block(input bit [1:0] hdr, input bit [127:0] pay,
                              input bit gaps);
        send_bit(hdr[0], gaps);
        send_bit(hdr[1], gaps);
        for (int i = 0; i < 128; i++) send_bit(pay[i], gaps);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) tick();
    endtask

    function automatic bit [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Ones-only preamble keeps every pre-block alignment candidate invalid.
    task automatic acquire(input bit [127:0] pay);
        repeat (37) send_bit(1'b1, 1'b0);
        repeat (6) send_block(2'b01, pay, 1'b0);
        idle(2);
    endtask

    initial begin
        int base;
        bit [1:0] h;

        // Reset
        rst1 = 1'b1;
        repeat (3) begin
            bit_valid = 1'($urandom_range(0, 1));
            bit_in    = 1'($urandom_range(0, 1));
            tick();
            mon_en = 1'b1;
        end
        #3;
        check("rst_blk_valid", {127'd0, blk_valid}, 128'd0);
        check("rst_blk_os", {127'd0, blk_os}, 128'd0);
        check("rst_blk_data", blk_data, 128'd0);
        check("rst_locked", {127'd0, locked}, 128'd0);
        check("rst_hdr_err", {127'd0, hdr_err}, 128'd0);
        rst1 = 1'b0;
        idle(2);

        // Acquisition: locked after the 4th header, blocks 5 and 6 emitted
        base = blk_seen;
        acquire(PAT);
        check("acq_locked", {127'd0, locked}, 128'd1);
        check("acq_blocks", 128'(blk_seen - base), 128'd2);

        // Ordered set with byte 0 = 00, then a data block
        base = blk_seen;
        send_block(2'b10, {rand128() >> 8, 8'h00}, 1'b0);
        send_block(2'b01, rand128(), 1'b0);
        idle(2);
        check("os_blocks", 128'(blk_seen - base), 128'd2);

        // Loss of lock: 3 bad headers keep lock, the 4th drops it
        repeat (3) send_block(2'b11, rand128(), 1'b0);
        idle(2);
        check("locked_after_3_bad", {127'd0, locked}, 128'd1);
        send_block(2'b11, rand128(), 1'b0);
        idle(2);
        check("unlocked_after_4_bad", {127'd0, locked}, 128'd0);

        // Re-lock on the continuing aligned stream
        base = blk_seen;
        repeat (5) send_block(2'b01, rand128(), 1'b0);
        idle(2);
        check("relock_locked", {127'd0, locked}, 128'd1);
        check("relock_blocks", 128'(blk_seen - base), 128'd1);

        // bit_valid gaps
        base = blk_seen;
        repeat (6) send_block(2'b01, rand128(), 1'b1);
        idle(2);
        check("gap_blocks", 128'(blk_seen - base), 128'd6);

        // Random headers and gaps
        repeat (20) begin
            h = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3)
                                            : 2'($urandom_range(1, 2));
            send_block(h, rand128(), 1'($urandom_range(0, 1)));
        end

        // Reset mid-block, then re-acquire
        repeat (60) send_bit(1'($urandom_range(0, 1)), 1'b0);
        rst1 = 1'b1;
        idle(2);
        rst1 = 1'b0;
        base = blk_seen;
        acquire(rand128());
        check("post_rst_locked", {127'd0, locked}, 128'd1);
        check("post_rst_blocks", 128'(blk_seen - base), 128'd2);

        idle(5);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_lane_130b_decoder.md
# rx_lane_130b_decoder

Single-lane 128b/130b receive decoder: the far end of the 4-lane logical transmitter. It takes one serial lane bit per qualified clock and acquires block alignment from the 2-bit sync headers. It emits each 128-bit payload with its block type and optionally descrambles data-block payloads. Four instances, one per lane, sit behind the lane deserializers and ahead of the data-link receive path.

## Interface
- LOCK_CNT, 4: consecutive valid sync headers needed to declare lock (range 1..15)
- UNLOCK_CNT, 4: consecutive invalid sync headers, while locked, that force re-hunt (range 1..15)
- LFSR_SEED, 23'h1DBFBC: descrambler seed
- clk8  in  1  bit-rate clock; all logic on rising edge
- rst1  in  1  reset; synchronous, active-high
- bit_valid  in  1  bit_in qualifier; state advances only when high
- bit_in  in  1  serial lane bit, first-transmitted first
- blk_valid  out  1  one-cycle pulse: blk_data/blk_os hold a new block
- blk_os  out  1  1 = ordered-set block (header 2'b10), 0 = data block (header 2'b01)
- blk_data  out  128  block payload; byte 0 = blk_data[7:0], first received
- locked  out  1  level, high in LOCKED
- hdr_err  out  1  one-cycle pulse: invalid header at a block boundary in VERIFY or LOCKED

## Operation
- 130-bit shift register sr: on bit_valid, sr <= {bit_in, sr[129:1]}. After 130 bits, sr[0] is the first bit received. hdr = sr[1:0]; payload = sr[129:2].
- Valid header: 2'b01 (data) or 2'b10 (ordered set); 2'b00 and 2'b11 are invalid.
- fill counter (0..130, saturating) counts bits since reset/hunt entry. bit_cnt (0..129) tracks the position within a block. A boundary is a cycle where, after the shift, bit_cnt has wrapped to 0.
- FSM:
  - HUNT: fill = 130 and hdr valid after a shift -> VERIFY, good_cnt = 1, bit_cnt = 0. Each bit is a candidate, giving implicit 1-bit slip.
  - VERIFY: at each boundary, valid hdr increments good_cnt; reaching LOCK_CNT -> LOCKED. Invalid hdr -> HUNT, fill = 0, hdr_err pulse.
  - LOCKED: at each boundary, blk_valid pulses. Valid hdr clears bad_cnt. Invalid hdr increments bad_cnt and pulses hdr_err. bad_cnt reaching UNLOCK_CNT -> HUNT, fill = 0, locked drops.
- While LOCKED, a block with an invalid header is still output, with blk_os = sr[1], blk_valid = 1 and hdr_err = 1.
- No block output in HUNT or VERIFY.
- Reset outputs: blk_valid 0, blk_os 0, blk_data 0, locked 0, hdr_err 0. State HUNT, all counters 0, LFSR = LFSR_SEED.
- rst1 mid-block discards the partial block; no pulse follows.

## Timing
- blk_valid, blk_data, blk_os and hdr_err are registered. They are valid in the cycle after the clock edge that shifted in the block's 130th bit.
- locked rises in the cycle after the LOCK_CNT-th good boundary; the first blk_valid comes one block later.
- Outputs other than pulses hold between blk_valid pulses.
- bit_valid low freezes every counter, the FSM and the LFSR. Pulses still last exactly one cycle.
- Minimum blk_valid spacing is 130 qualified bits.

## Configuration
- RX_DESCRAMBLE_EN defined:
  - Data-block payloads are XORed with a Galois LFSR, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, 128 steps per block, bit 0 first. The result is the computed next state, so the block is ready in the same output cycle.
  - The LFSR advances only on data blocks in LOCKED and is never applied to ordered-set payloads.
  - The LFSR reloads LFSR_SEED on entry to LOCKED and after an ordered set whose payload byte 0 is 8'h00.
- Not defined: payload passes through unmodified; no LFSR logic is synthesized.

## Test plan
- Reset: hold rst1 = 1 for 3 cycles with random bit_in -> all outputs 0, locked 0.
- Acquisition: 37 junk bits, then 6 blocks with header 2'b01 and payload 128'h0123...CDEF (macro off) -> locked after the 4th header. Blocks 5 and 6 are output with blk_os = 0 and blk_data exactly as sent.
- Ordered set: locked, send header 2'b10 with byte 0 = 8'h00 -> blk_os = 1, payload unchanged, LFSR reseeded (macro on).
- Loss of lock: locked, send 3 blocks with header 2'b11 -> 3 hdr_err pulses, locked stays 1. A 4th bad header drops locked in the next cycle; no further blk_valid until re-lock.
- bit_valid gaps: toggle bit_valid at 50% random duty during 6 blocks -> identical blk_data sequence, each blk_valid exactly one cycle.
- Descramble (RX_DESCRAMBLE_EN): feed the 4-lane transmitter's lane-0 output with scrambling enabled and 16 random DLL words -> blk_data matches the transmitter input words in order.
